univ_shift_reg: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with clock enable, synchronous reset and eight operating modes.
- Modes: hold, logical shift left, logical shift right, rotate left, rotate right, parallel load, arithmetic shift right, clear.
- A shift counter with a done flag lets the block act as a serializer or deserializer for later labs, such as UART and SPI datapaths.

---
 rtl/univ_shift_reg_pkg.sv | 24 ++
 rtl/univ_shift_reg_if.sv | 37 +++
 rtl/univ_shift_reg_sat_counter.sv | 35 +++
 rtl/univ_shift_reg.sv | 69 ++++++
 tb/tb_univ_shift_reg.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/univ_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register:
//   - 3-bit mode constants selecting the register operation
//   - is_shift_mode(): 1 for the five modes that advance the shift counter
// -----------------------------------------------------------------------------
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROL  = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_CLR  = 3'b111;

   // Shifts and rotates count; HOLD, LOAD and CLR do not.
   function automatic logic is_shift_mode(input logic [2:0] mode);
      return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
             (mode == MODE_ROR) || (mode == MODE_ASR);
   endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_if
// Bundles the control and data signals of univ_shift_reg.
//   master : drives en, mode, d_par, sin_l, sin_r; observes q, sout_l,
//            sout_r, shift_cnt, done
//   slave  : the register block itself (opposite directions)
// Handshake: there is no ready; en acts as a per-cycle valid for the
// command (mode, d_par, sin_l, sin_r) and the block accepts it on every
// rising edge where en=1. Outputs are valid every cycle after reset.
// -----------------------------------------------------------------------------
interface univ_shift_reg_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d_par;
   logic             sin_l;
   logic             sin_r;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic [CW-1:0]    shift_cnt;
   logic             done;

   modport master (
      output en, mode, d_par, sin_l, sin_r,
      input  q, sout_l, sout_r, shift_cnt, done
   );

   modport slave (
      input  en, mode, d_par, sin_l, sin_r,
      output q, sout_l, sout_r, shift_cnt, done
   );

endinterface

// File: rtl/univ_shift_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter with synchronous reset/clear, increment enable and saturation.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (count -> 0)
//   clr    : synchronous clear (count -> 0)
//   inc    : increment request; ignored once the count equals MAX
//   cnt    : current count
//   at_max : high while cnt == MAX
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int MAX = 8,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         at_max
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX_V)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// WIDTH-bit register with clock enable, synchronous reset and eight modes
// (hold, shl, shr, rol, ror, load, asr, clr), plus a saturating shift counter
// so the block can serialise or deserialise a word.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; q <= RESET_VAL, count <= 0
//   bus : univ_shift_reg_if slave -- en, mode, d_par, sin_l, sin_r in;
//         q, sout_l (MSB), sout_r (LSB), shift_cnt, done out
// -----------------------------------------------------------------------------
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   univ_shift_reg_if.slave    bus
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] q_r;
   logic [CW-1:0]    cnt;
   logic             cnt_max;
   logic             cnt_clr;
   logic             cnt_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r <= RESET_VAL;
      end else if (bus.en) begin
         case (bus.mode)
            MODE_SHL:  q_r <= {q_r[WIDTH-2:0], bus.sin_r};
            MODE_SHR:  q_r <= {bus.sin_l, q_r[WIDTH-1:1]};
            MODE_ROL:  q_r <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            MODE_ROR:  q_r <= {q_r[0], q_r[WIDTH-1:1]};
            MODE_LOAD: q_r <= bus.d_par;
            MODE_ASR:  q_r <= {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            MODE_CLR:  q_r <= '0;  // zero, deliberately not RESET_VAL
            default:   q_r <= q_r; // MODE_HOLD
         endcase
      end
   end

   // LOAD and CLR restart the count on the same edge that writes q.
   assign cnt_clr = bus.en && ((bus.mode == MODE_LOAD) || (bus.mode == MODE_CLR));
   assign cnt_inc = bus.en && is_shift_mode(bus.mode);

   sat_counter #(
      .MAX (WIDTH),
      .W   (CW)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .cnt    (cnt),
      .at_max (cnt_max)
   );

   assign bus.q         = q_r;
   assign bus.sout_l    = q_r[WIDTH-1];
   assign bus.sout_r    = q_r[0];
   assign bus.shift_cnt = cnt;
   assign bus.done      = cnt_max;

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// The driver applies one command per cycle, advances an arithmetic model
// and pushes the expected outputs; the monitor pops and compares after each
// edge. Directed steps also check against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;
   import usr_pkg::*;

   localparam int         W   = 8;
   localparam int         M   = 256;   // 2**W
   localparam int         H   = 128;   // weight of the MSB
   localparam logic [7:0] RV  = 8'hA5;
   localparam int         EW  = 8 + 4 + 3;

   logic clk;
   logic rst;

   univ_shift_reg_if #(.WIDTH(W)) bus ();

   univ_shift_reg #(
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int mq = 0;   // model register value
   int mc = 0;   // model shift count

   function automatic logic [EW-1:0] pack_exp(input int qv, input int cv);
      logic [7:0] q8;
      logic [3:0] c4;
      q8 = 8'(qv);
      c4 = 4'(cv);
      return {q8, c4, (cv == W), (qv >= H), ((qv % 2) == 1)};
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] d, input logic sl, input logic sr);
      @(negedge clk);
      rst       = r;
      bus.en    = e;
      bus.mode  = m;
      bus.d_par = d;
      bus.sin_l = sl;
      bus.sin_r = sr;
      @(posedge clk);
      if (r) begin
         mq = int'(RV);
         mc = 0;
      end else if (e) begin
         case (m)
            MODE_SHL:  mq = (mq * 2 + int'(sr)) % M;
            MODE_SHR:  mq = mq / 2 + int'(sl) * H;
            MODE_ROL:  mq = (mq * 2) % M + mq / H;
            MODE_ROR:  mq = mq / 2 + (mq % 2) * H;
            MODE_LOAD: mq = int'(d);
            MODE_ASR:  mq = mq / 2 + ((mq >= H) ? H : 0);
            MODE_CLR:  mq = 0;
            default:   mq = mq;
         endcase
         if (m == MODE_LOAD || m == MODE_CLR) mc = 0;
         else if (m != MODE_HOLD) mc = (mc < W) ? mc + 1 : W;
      end
      exp_q.push_back(pack_exp(mq, mc));
   endtask

   // Compare against hand-derived constants shortly after the last edge.
   task automatic check_dir(input string name, input logic [7:0] eq,
                            input logic [3:0] ec, input logic ed);
      #2;
      checks++;
      if (bus.q !== eq || bus.shift_cnt !== ec || bus.done !== ed) begin
         errors++;
         $display("FAIL %s: got q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b",
                  name, bus.q, bus.shift_cnt, bus.done, eq, ec, ed);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.q, bus.shift_cnt, bus.done, bus.sout_l, bus.sout_r};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL model_cmp @%0t: got q=%h cnt=%0d done=%b sl=%b sr=%b, expected q=%h cnt=%0d done=%b sl=%b sr=%b",
                        $time, a[14:7], a[6:3], a[2], a[1], a[0],
                        e[14:7], e[6:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0] m;
      int         guard;
      rst = 1'b0; bus.en = 1'b0; bus.mode = MODE_HOLD;
      bus.d_par = '0; bus.sin_l = 1'b0; bus.sin_r = 1'b0;

      // Reset and enable
      step(1, 0, MODE_HOLD, 8'h00, 0, 0);  check_dir("reset", 8'hA5, 0, 0);
      step(0, 0, MODE_LOAD, 8'h3C, 0, 0);  check_dir("en_low_load", 8'hA5, 0, 0);

      // Load then shift left with sin_r=1
      step(0, 1, MODE_LOAD, 8'h81, 0, 0);  check_dir("load_81", 8'h81, 0, 0);
      step(0, 1, MODE_SHL, 8'h00, 0, 1);   check_dir("shl_1", 8'h03, 1, 0);
      step(0, 1, MODE_SHL, 8'h00, 0, 1);   check_dir("shl_2", 8'h07, 2, 0);
      for (int i = 0; i < 5; i++) step(0, 1, MODE_SHL, 8'h00, 0, 1);
      check_dir("shl_7", 8'hFF, 7, 0);
      step(0, 1, MODE_SHL, 8'h00, 0, 1);   check_dir("shl_8_done", 8'hFF, 8, 1);
      step(0, 1, MODE_SHL, 8'h00, 0, 0);   check_dir("shl_9_sat", 8'hFE, 8, 1);

      // Rotate round trip
      step(0, 1, MODE_LOAD, 8'hB4, 0, 0);
      step(0, 1, MODE_ROL, 8'h00, 0, 0);   check_dir("rol_1", 8'h69, 1, 0);
      step(0, 1, MODE_ROL, 8'h00, 0, 0);
      step(0, 1, MODE_ROL, 8'h00, 0, 0);   check_dir("rol_3", 8'hA5, 3, 0);
      for (int i = 0; i < 3; i++) step(0, 1, MODE_ROR, 8'h00, 0, 0);
      check_dir("ror_3", 8'hB4, 6, 0);

      // Arithmetic versus logical right shift
      step(0, 1, MODE_LOAD, 8'h90, 0, 0);
      step(0, 1, MODE_ASR, 8'h00, 0, 0);   check_dir("asr_1", 8'hC8, 1, 0);
      step(0, 1, MODE_ASR, 8'h00, 0, 0);   check_dir("asr_2", 8'hE4, 2, 0);
      step(0, 1, MODE_LOAD, 8'h90, 0, 0);
      step(0, 1, MODE_SHR, 8'h00, 0, 0);   check_dir("shr_1", 8'h48, 1, 0);

      // Clear, reset and count recovery
      step(0, 1, MODE_LOAD, 8'h55, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, MODE_SHL, 8'h00, 0, 0);
      check_dir("shl_x4", 8'h50, 4, 0);
      step(0, 1, MODE_CLR, 8'h00, 0, 0);   check_dir("clr", 8'h00, 0, 0);
      step(0, 1, MODE_SHL, 8'h00, 0, 1);
      step(0, 1, MODE_SHL, 8'h00, 0, 1);   check_dir("shl_after_clr", 8'h03, 2, 0);
      step(1, 0, MODE_HOLD, 8'h00, 0, 0);  check_dir("rst_pulse", 8'hA5, 0, 0);

      // Hold and priority
      step(0, 1, MODE_SHR, 8'h00, 1, 0);
      for (int i = 0; i < 5; i++) step(0, 1, MODE_HOLD, 8'h00, 0, 0);
      check_dir("hold_x5", 8'hD2, 1, 0);
      step(1, 1, MODE_LOAD, 8'hFF, 0, 0);  check_dir("rst_priority", 8'hA5, 0, 0);

      // Randomised traffic, biased toward shifts so saturation is reached
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) m = 3'($urandom_range(0, 7));
         else begin
            case ($urandom_range(0, 4))
               0:       m = MODE_SHL;
               1:       m = MODE_SHR;
               2:       m = MODE_ROL;
               3:       m = MODE_ROR;
               default: m = MODE_ASR;
            endcase
         end
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) != 0), m,
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end

      // Drain the scoreboard with a bounded wait
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d entries pending, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
